// File: rtl/alarm_ctrl_pkg.sv
// rtl/alarm_ctrl_pkg.sv - shared state encodings and width helpers for the alarm controller
//
// Contents:
//   state_t   : 2-bit FSM encoding (IDLE, OPEN, ALARM, LOCKOUT)
//   bits_for  : number of bits needed to hold a non-negative value
//   max3      : largest of three integers (used to size the tick timer)
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPEN    = 2'd1,
        ST_ALARM   = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    // Bits required to represent 'value' itself (not value-1); never less than 1.
    function automatic int bits_for(input int value);
        return (value < 2) ? 1 : $clog2(value + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing one tick every TICK_DIV clock cycles
//
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   restart : synchronous clear of the prescaler count
//   tick    : high for one cycle when the count is at TICK_DIV-1
module tick_gen
    import alarm_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int             CW   = bits_for(TICK_DIV - 1);
    localparam logic [CW-1:0]  TERM = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic [CW-1:0] count;

    assign tick = (count == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart || tick) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - safe-box access/alarm sequencer with timed open, alarm and lockout phases
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   attempt_valid : one-cycle pulse, comparator result valid
//   attempt_ok    : 1 = code matched (qualified by attempt_valid)
//   lock_req      : close the lock early while OPEN
//   admin_clear   : abort ALARM/LOCKOUT, zero the fail count
//   unlock        : lock solenoid enable
//   alarm         : alarm LED/buzzer drive
//   locked_out    : attempts currently refused
//   fail_cnt      : consecutive wrong attempts (saturates at MAX_FAILS)
//   attempt_ack   : pulse one cycle after an accepted attempt
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int  TICK_DIV      = 5000000,
    parameter int  MAX_FAILS     = 3,
    parameter int  OPEN_TICKS    = 50,
    parameter int  ALARM_TICKS   = 300,
    parameter int  LOCKOUT_TICKS = 600,
    localparam int FW            = bits_for(MAX_FAILS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          attempt_valid,
    input  logic          attempt_ok,
    input  logic          lock_req,
    input  logic          admin_clear,
    output logic          unlock,
    output logic          alarm,
    output logic          locked_out,
    output logic [FW-1:0] fail_cnt,
    output logic          attempt_ack
);

    localparam int            TW        = bits_for(max3(OPEN_TICKS, ALARM_TICKS, LOCKOUT_TICKS));
    localparam logic [TW-1:0] OPEN_N    = TW'(OPEN_TICKS);
    localparam logic [TW-1:0] ALARM_N   = TW'(ALARM_TICKS);
    localparam logic [TW-1:0] LOCKOUT_N = TW'(LOCKOUT_TICKS);
    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [FW-1:0] F_ONE     = FW'(1);
    localparam logic [FW-1:0] F_MAX     = FW'(MAX_FAILS);

    state_t        state;
    state_t        state_next;
    logic [FW-1:0] fail_next;
    logic [FW-1:0] fail_inc;
    logic          ack_next;
    logic          unlock_next;
    logic          alarm_next;
    logic          locked_out_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_load;
    logic          tick;
    logic          restart;
    logic          timeout;

    // Prescaler realigns on every state change so each timed state lasts N*TICK_DIV cycles.
    assign restart = (state_next != state);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // The tick that would take the timer to zero ends the state on this edge.
    assign timeout  = tick && (timer == T_ONE);
    assign fail_inc = fail_cnt + F_ONE;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, fail count and ack; priority admin_clear > timeout > lock_req > attempt
    always_comb begin
        state_next = state;
        fail_next  = fail_cnt;
        ack_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (admin_clear) begin
                    fail_next = '0;
                end else if (attempt_valid) begin
                    ack_next = 1'b1;
                    if (attempt_ok) begin
                        fail_next  = '0;
                        state_next = ST_OPEN;
                    end else begin
                        fail_next = fail_inc;
                        if (fail_inc == F_MAX) begin
                            state_next = ST_ALARM;
                        end
                    end
                end
            end
            ST_OPEN: begin
                // admin_clear has no meaning while open; only timeout/lock_req close it
                if (timeout || lock_req) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ALARM: begin
                if (admin_clear) begin
                    state_next = ST_IDLE;
                    fail_next  = '0;
                end else if (timeout) begin
                    state_next = ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                if (admin_clear || timeout) begin
                    state_next = ST_IDLE;
                    fail_next  = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                fail_next  = '0;
            end
        endcase
    end

    // Output decode from the next state so outputs switch on the entering edge
    always_comb begin
        unlock_next     = (state_next == ST_OPEN);
        alarm_next      = (state_next == ST_ALARM);
        locked_out_next = (state_next == ST_ALARM) || (state_next == ST_LOCKOUT);
        case (state_next)
            ST_OPEN:    timer_load = OPEN_N;
            ST_ALARM:   timer_load = ALARM_N;
            ST_LOCKOUT: timer_load = LOCKOUT_N;
            default:    timer_load = '0;
        endcase
    end

    // Registered outputs, fail counter and tick timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unlock      <= 1'b0;
            alarm       <= 1'b0;
            locked_out  <= 1'b0;
            attempt_ack <= 1'b0;
            fail_cnt    <= '0;
            timer       <= '0;
        end else begin
            unlock      <= unlock_next;
            alarm       <= alarm_next;
            locked_out  <= locked_out_next;
            attempt_ack <= ack_next;
            fail_cnt    <= fail_next;
            if (restart) begin
                timer <= timer_load;
            end else if (tick && (timer != '0)) begin
                timer <= timer - T_ONE;
            end
        end
    end

endmodule
